trackball_quad_gen: RTL and testbench
=====================================

TRACKBALL_QUAD_GEN -- requirements
Module: trackball_quad_gen

Interface
REQ-001 Parameter CHANNELS, default 2: number of independent quadrature channels (X, Y, ...), range 1..8.
REQ-002 Parameter DELTA_W, default 8: width of each signed delta input.
REQ-003 Parameter ACC_W, default 12: width of each signed pending-step accumulator; must satisfy ACC_W >= DELTA_W+1.
REQ-004 Parameter STEP_DIV, default 40: clocks per quadrature quarter-step; must be >= 2.
REQ-005 Port clk, input, 1: system clock; the only clock.
REQ-006 Port reset, input, 1: synchronous, active-high reset.
REQ-007 Port delta_in, input, CHANNELS*DELTA_W: two's-complement delta per channel; channel i occupies bits [i*DELTA_W +: DELTA_W].
REQ-008 Port delta_valid, input, CHANNELS: per-channel strobe; the delta is accepted when high.
REQ-009 Port delta_ready, output, CHANNELS: per-channel accept indication.
REQ-010 Port qa, output, CHANNELS: quadrature phase A per channel, registered.
REQ-011 Port qb, output, CHANNELS: quadrature phase B per channel, registered.
REQ-012 Port busy, output, CHANNELS: high while the channel accumulator is nonzero.

Function
REQ-013 Each channel holds a 2-bit phase state {A,B} and an ACC_W-bit signed accumulator; qa/qb drive the phase state directly.
REQ-014 delta_ready[i] is low during the reset cycle and high in every other cycle; a delta is accepted in a cycle where delta_valid[i] and delta_ready[i] are both high.
REQ-015 An accepted delta is sign-extended to ACC_W and added to the accumulator at the closing clock edge of the accept cycle.
REQ-016 A shared prescaler counts 0..STEP_DIV-1 and wraps to 0; tick is high in the cycle where the count equals STEP_DIV-1.
REQ-017 The first tick occurs in the STEP_DIV-th cycle after reset deasserts.
REQ-018 On a tick with accumulator > 0: the phase advances forward 00->10->11->01->00 (A leads) and the accumulator decrements by 1.
REQ-019 On a tick with accumulator < 0: the phase advances in reverse 00->01->11->10->00 and the accumulator increments by 1.
REQ-020 On a tick with accumulator == 0, the phase is held; at most one quarter-step per channel per tick.
REQ-021 Accept and tick in the same cycle: next accumulator = acc + delta - sign(acc), where the step decision uses the pre-add accumulator.
REQ-022 Exactly one of qa/qb changes per step (Gray sequence); no glitch states.
REQ-023 busy[i] is registered and equals (accumulator[i] != 0) after each edge.
REQ-024 Channels are fully independent apart from the shared tick.

Reset
REQ-025 While reset is high, at the clock edge: all phase states = 00, all accumulators = 0, prescaler = 0, qa = qb = 0, busy = 0.
REQ-026 Reset asserted mid-step discards pending steps; the phase returns to 00 with no intermediate states.

Configuration
REQ-027 Macro QUAD_SATURATE_EN defined: accumulator additions that overflow clamp to +(2^(ACC_W-1)-1) or -(2^(ACC_W-1)).
REQ-028 Macro QUAD_SATURATE_EN undefined: accumulator additions wrap modulo 2^ACC_W (two's complement).

Verification (CHANNELS=2, DELTA_W=8, ACC_W=10, STEP_DIV=4)
REQ-029 Hold reset 3 cycles, then release -> qa=qb=00, busy=00, delta_ready=11 in the first cycle after release.
REQ-030 Channel 0 delta +3 accepted in cycle 0 -> ch0 {A,B} = 10, 11, 01 after ticks 1, 2, 3; busy[0] falls after tick 3; ch1 stays 00.
REQ-031 Channel 1 delta -2 -> ch1 {A,B} = 01 then 11; busy[1] falls after the 2nd tick.
REQ-032 Channel 0 accumulator = 2 and delta +1 accepted in a tick cycle -> one forward step and accumulator = 2.
REQ-033 Channel 0 accumulator = 500 plus delta +127 -> 511 with QUAD_SATURATE_EN; -397 without it.
REQ-034 Reset asserted with accumulator = 5 and phase 11 -> next cycle phase 00, busy 0, and no further steps after release.

Source files
------------

// File: rtl/trackball_quad_gen.sv
// Multi-channel quadrature (A/B Gray) step generator driven by signed deltas.
// Define QUAD_SATURATE_EN to clamp accumulator additions instead of wrapping.
module trackball_quad_gen #(
  parameter int CHANNELS = 2,
  parameter int DELTA_W  = 8,
  parameter int ACC_W    = 12,
  parameter int STEP_DIV = 40
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [CHANNELS*DELTA_W-1:0]   delta_in,
  input  logic [CHANNELS-1:0]           delta_valid,
  output logic [CHANNELS-1:0]           delta_ready,
  output logic [CHANNELS-1:0]           qa,
  output logic [CHANNELS-1:0]           qb,
  output logic [CHANNELS-1:0]           busy
);

  localparam int CNT_W = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_DIV - 1);

  // Handshake: a delta transfers on any edge where valid and ready are both
  // high; ready is dropped only while reset is asserted.
  assign delta_ready = {CHANNELS{~reset}};

  logic [CNT_W-1:0] presc_q;
  logic [CNT_W-1:0] presc_d;
  logic             tick;

  always_comb begin
    tick    = (presc_q == CNT_LAST);
    presc_d = tick ? '0 : presc_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    logic [ACC_W-1:0]   acc_q;
    logic [ACC_W-1:0]   acc_d;
    logic [1:0]         ph_q;
    logic [1:0]         ph_d;
    logic               busy_q;
    logic               busy_d;
    logic               accept;
    logic [DELTA_W-1:0] delta_raw;
    logic [ACC_W-1:0]   delta_ext;
    logic [ACC_W-1:0]   add_acc;
    logic [ACC_W-1:0]   step_acc;
    logic               step_up;
    logic               step_dn;
`ifdef QUAD_SATURATE_EN
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
    logic [ACC_W:0]     add_sum;
`endif

    always_comb begin
      accept    = delta_valid[g] & delta_ready[g];
      delta_raw = delta_in[g*DELTA_W +: DELTA_W];
      delta_ext = accept ? {{(ACC_W-DELTA_W){delta_raw[DELTA_W-1]}}, delta_raw} : '0;

      // Step direction is decided on the pre-add accumulator.
      step_up = tick & ~acc_q[ACC_W-1] & (|acc_q);
      step_dn = tick & acc_q[ACC_W-1];

`ifdef QUAD_SATURATE_EN
      add_sum = {acc_q[ACC_W-1], acc_q} + {delta_ext[ACC_W-1], delta_ext};
      if (!add_sum[ACC_W] && add_sum[ACC_W-1]) begin
        add_acc = ACC_MAX;
      end else if (add_sum[ACC_W] && !add_sum[ACC_W-1]) begin
        add_acc = ACC_MIN;
      end else begin
        add_acc = add_sum[ACC_W-1:0];
      end
`else
      add_acc = acc_q + delta_ext;
`endif

      if (step_up) begin
        step_acc = ACC_W'(1);
      end else if (step_dn) begin
        step_acc = '1;
      end else begin
        step_acc = '0;
      end
      acc_d  = add_acc - step_acc;
      busy_d = (acc_d != '0);

      ph_d = ph_q;
      if (step_up) begin
        case (ph_q)
          2'b00:   ph_d = 2'b10;
          2'b10:   ph_d = 2'b11;
          2'b11:   ph_d = 2'b01;
          default: ph_d = 2'b00;
        endcase
      end else if (step_dn) begin
        case (ph_q)
          2'b00:   ph_d = 2'b01;
          2'b01:   ph_d = 2'b11;
          2'b11:   ph_d = 2'b10;
          default: ph_d = 2'b00;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        acc_q  <= '0;
        ph_q   <= 2'b00;
        busy_q <= 1'b0;
      end else begin
        acc_q  <= acc_d;
        ph_q   <= ph_d;
        busy_q <= busy_d;
      end
    end

    assign qa[g]   = ph_q[1];
    assign qb[g]   = ph_q[0];
    assign busy[g] = busy_q;
  end

endmodule

// File: tb/tb_trackball_quad_gen.sv
// Bench for trackball_quad_gen: directed scenarios plus random deltas checked
// every cycle against an arithmetic model of pending steps and Gray position.
module tb_trackball_quad_gen;
  localparam int CH  = 2;
  localparam int DW  = 8;
  localparam int AW  = 10;
  localparam int DIV = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [CH*DW-1:0]  delta_in = '0;
  logic [CH-1:0]     delta_valid = '0;
  logic [CH-1:0]     delta_ready;
  logic [CH-1:0]     qa;
  logic [CH-1:0]     qb;
  logic [CH-1:0]     busy;

  int total = 0;
  int bad   = 0;

  trackball_quad_gen #(.CHANNELS(CH), .DELTA_W(DW), .ACC_W(AW), .STEP_DIV(DIV)) dut (
    .clk(clk), .reset(reset), .delta_in(delta_in), .delta_valid(delta_valid),
    .delta_ready(delta_ready), .qa(qa), .qb(qb), .busy(busy)
  );

  always #5 clk = ~clk;

  // Model: signed pending count and position in the forward Gray cycle.
  logic [1:0] seq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
  int m_acc [CH];
  int m_pos [CH];
  int m_cnt;
  bit started = 0;

  function automatic int fix_acc(int s);
    int m;
    int h;
    int r;
    m = 1 << AW;
    h = m / 2;
`ifdef QUAD_SATURATE_EN
    if (s > h - 1) return h - 1;
    if (s < -h) return -h;
    return s;
`else
    r = (s + h) % m;
    if (r < 0) r += m;
    return r - h;
`endif
  endfunction

  always @(posedge clk) begin
    int n_acc [CH];
    int n_pos [CH];
    int n_cnt;
    bit tk;
    int d;
    int st;
    int s;
    if (reset) begin
      for (int c = 0; c < CH; c++) begin
        n_acc[c] = 0;
        n_pos[c] = 0;
      end
      n_cnt = 0;
    end else begin
      tk    = (m_cnt == DIV - 1);
      n_cnt = tk ? 0 : m_cnt + 1;
      for (int c = 0; c < CH; c++) begin
        d  = delta_valid[c] ? int'($signed(delta_in[c*DW +: DW])) : 0;
        st = !tk ? 0 : (m_acc[c] > 0) ? 1 : (m_acc[c] < 0) ? -1 : 0;
        s  = fix_acc(m_acc[c] + d);
`ifdef QUAD_SATURATE_EN
        n_acc[c] = s - st;
`else
        n_acc[c] = fix_acc(s - st);
`endif
        n_pos[c] = (m_pos[c] + 4 + st) % 4;
      end
    end
    m_acc   <= n_acc;
    m_pos   <= n_pos;
    m_cnt   <= n_cnt;
    started <= 1'b1;
  end

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%h expected=%h", name, $time, got, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [CH-1:0] e_qa;
    logic [CH-1:0] e_qb;
    logic [CH-1:0] e_busy;
    logic [1:0]    p;
    if (started) begin
      for (int c = 0; c < CH; c++) begin
        p         = seq[m_pos[c]];
        e_qa[c]   = p[1];
        e_qb[c]   = p[0];
        e_busy[c] = (m_acc[c] != 0);
      end
      chk("model_qa", 8'(qa), 8'(e_qa));
      chk("model_qb", 8'(qb), 8'(e_qb));
      chk("model_busy", 8'(busy), 8'(e_busy));
      chk("model_ready", 8'(delta_ready), 8'({CH{~reset}}));
    end
  end

  task automatic do_reset();
    reset       = 1'b1;
    delta_valid = '0;
    delta_in    = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic drive(input int c, input int d);
    delta_in[c*DW +: DW] = DW'(d);
    delta_valid[c]       = 1'b1;
  endtask

  function automatic logic [7:0] ph(input int c);
    return 8'({qa[c], qb[c]});
  endfunction

  int dtab [6] = '{127, 127, 127, 119, 1, 127};

  initial begin
    // Reset release and single-channel forward run.
    do_reset();
    @(negedge clk);
    chk("rst_qa", 8'(qa), 8'h00);
    chk("rst_qb", 8'(qb), 8'h00);
    chk("rst_busy", 8'(busy), 8'h00);
    chk("rst_ready", 8'(delta_ready), 8'h03);
    drive(0, 3);
    @(posedge clk); #1 delta_valid = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("fwd_t1", ph(0), 8'h02);
    chk("fwd_t1_ch1", ph(1), 8'h00);
    chk("fwd_t1_busy", 8'(busy), 8'h01);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("fwd_t2", ph(0), 8'h03);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("fwd_t3", ph(0), 8'h01);
    chk("fwd_t3_busy", 8'(busy), 8'h00);
    chk("fwd_t3_ch1", ph(1), 8'h00);

    // Channel 1 reverse run.
    drive(1, -2);
    @(posedge clk); #1 delta_valid = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rev_t1", ph(1), 8'h01);
    chk("rev_t1_busy", 8'(busy), 8'h02);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("rev_t2", ph(1), 8'h03);
    chk("rev_t2_busy", 8'(busy), 8'h00);

    // Accept coinciding with a tick: 2 + 1 - 1 keeps two steps pending.
    drive(0, 2);
    @(posedge clk); #1 delta_valid = '0;
    repeat (2) @(posedge clk);
    #1 drive(0, 1);
    @(posedge clk); #1 delta_valid = '0;
    @(negedge clk);
    chk("coinc_step", ph(0), 8'h00);
    chk("coinc_busy", 8'(busy), 8'h01);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("coinc_next", ph(0), 8'h02);
    chk("coinc_busy2", 8'(busy), 8'h01);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("coinc_last", ph(0), 8'h03);
    chk("coinc_busy3", 8'(busy), 8'h00);

    // Overflow: 500 + 127 clamps to 511 or wraps to -397; the next step shows the sign.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(0, dtab[i]);
      @(posedge clk); #1;
    end
    delta_valid = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
`ifdef QUAD_SATURATE_EN
    chk("ovf_dir", ph(0), 8'h03);
`else
    chk("ovf_dir", ph(0), 8'h00);
`endif
    chk("ovf_busy", 8'(busy), 8'h01);

    // Reset mid-run discards pending steps.
    do_reset();
    drive(0, 7);
    @(posedge clk); #1 delta_valid = '0;
    repeat (7) @(posedge clk);
    @(negedge clk);
    chk("mid_ph", ph(0), 8'h03);
    chk("mid_busy", 8'(busy), 8'h01);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_ph", ph(0), 8'h00);
    chk("mid_rst_busy", 8'(busy), 8'h00);
    chk("mid_rst_ready", 8'(delta_ready), 8'h00);
    @(posedge clk); #1 reset = 1'b0;
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("post_rst_ph", ph(0), 8'h00);
    chk("post_rst_busy", 8'(busy), 8'h00);

    // Random traffic with rare resets, then drain.
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      reset = ($urandom_range(0, 999) == 0);
      for (int c = 0; c < CH; c++) begin
        delta_valid[c] = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 9) == 0) begin
          delta_in[c*DW +: DW] = DW'($urandom_range(0, 255));
        end else begin
          delta_in[c*DW +: DW] = DW'(int'($urandom_range(0, 6)) - 3);
        end
      end
    end
    @(posedge clk); #1;
    reset       = 1'b0;
    delta_valid = '0;
    repeat (2600) @(posedge clk);
    @(negedge clk);
    chk("drain_busy", 8'(busy), 8'h00);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
